// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Line geometry is fixed at eight 32-bit words per line.
package icache_pkg;

    typedef enum logic [1:0] {LOOKUP, FILL_WAIT, FILL_WRITE} icache_state_t;

    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned LINE_W         = 256;
    localparam int unsigned OFFSET_W       = 3;
    localparam int unsigned BYTE_OFF_W     = 5;

    typedef logic [31:0] word_t;

    // Saturating increment for the performance counters.
    function automatic word_t sat_inc(input word_t v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// master = fetch stage plus instruction memory, slave = the cache.
interface icache_dm_if;

    logic [31:0]                      pc;
    logic                             rd_en;
    logic                             flush;
    icache_pkg::word_t                instr;
    logic                             hit;
    logic                             stall;
    logic [31:0]                      mem_addr;
    logic [icache_pkg::LINE_W-1:0]    mem_line;
    icache_pkg::word_t                hit_count;
    icache_pkg::word_t                miss_count;

    modport master (
        output pc, rd_en, flush, mem_line,
        input  instr, hit, stall, mem_addr, hit_count, miss_count
    );

    modport slave (
        input  pc, rd_en, flush, mem_line,
        output instr, hit, stall, mem_addr, hit_count, miss_count
    );

endinterface

// File: rtl/icache_line_store.sv
// Data, tag and valid storage for the direct-mapped cache.
// Asynchronous read by index, synchronous line write and clear-all.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned IDX_W     = $clog2(NUM_LINES),
    parameter int unsigned TAG_W     = 32 - BYTE_OFF_W - IDX_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear_all,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    always_ff @(posedge CLK) begin
        if (RST || clear_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: combinational hit path, blocking line fill
// after a fixed memory latency, saturating hit/miss counters.
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 16,
    parameter int unsigned MEM_LAT   = 1
) (
    input  logic        CLK,
    input  logic        RST,
    icache_dm_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 32 - BYTE_OFF_W - IDX_W;
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    icache_state_t     state_q;
    logic [CNT_W-1:0]  lat_cnt_q;
    logic [31:0]       fill_addr_q;
    word_t             hit_cnt_q;
    word_t             miss_cnt_q;

    logic [OFFSET_W-1:0] offset;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [31:0]         pc_line;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic              wr_en;
    logic              clear_all;

    logic lookup;
    logic hit;
    logic miss;

    assign offset   = bus.pc[BYTE_OFF_W-1:2];
    assign idx      = bus.pc[BYTE_OFF_W +: IDX_W];
    assign tag      = bus.pc[31 -: TAG_W];
    assign pc_line  = {bus.pc[31:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};
    assign fill_idx = fill_addr_q[BYTE_OFF_W +: IDX_W];
    assign fill_tag = fill_addr_q[31 -: TAG_W];

    assign lookup = (state_q == LOOKUP);
    // A flush cycle never hits and never starts a fill.
    assign hit    = lookup && bus.rd_en && !bus.flush && rd_valid && (rd_tag == tag);
    assign miss   = lookup && bus.rd_en && !bus.flush && !hit;

    assign clear_all = bus.flush;
    assign wr_en     = (state_q == FILL_WRITE) && !bus.flush;

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_line_store (
        .CLK       (CLK),
        .RST       (RST),
        .clear_all (clear_all),
        .rd_idx    (idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .wr_en     (wr_en),
        .wr_idx    (fill_idx),
        .wr_tag    (fill_tag),
        .wr_line   (bus.mem_line)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= LOOKUP;
            lat_cnt_q   <= '0;
            fill_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                LOOKUP: begin
                    if (hit) begin
                        hit_cnt_q <= sat_inc(hit_cnt_q);
                    end else if (miss) begin
                        miss_cnt_q  <= sat_inc(miss_cnt_q);
                        fill_addr_q <= pc_line;
                        lat_cnt_q   <= '0;
                        state_q     <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (bus.flush) begin
                        state_q <= LOOKUP;
                    end else if (lat_cnt_q == CNT_W'(MEM_LAT - 1)) begin
                        state_q <= FILL_WRITE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                FILL_WRITE: begin
                    state_q <= LOOKUP;
                end
                default: begin
                    state_q <= LOOKUP;
                end
            endcase
        end
    end

    assign bus.hit        = hit;
    assign bus.stall      = miss || !lookup;
    assign bus.instr      = hit ? rd_line[{offset, 5'b0} +: 32] : '0;
    assign bus.mem_addr   = lookup ? pc_line : fill_addr_q;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: a hand-derived vector table, directed corner
// sequences and a randomized run, all checked against a behavioural cache model.
module tb_icache_dm;
    import icache_pkg::*;

    localparam int unsigned NL = 16;
    localparam int unsigned ML = 2;

    logic CLK;
    logic RST;
    icache_dm_if bus();

    icache_dm #(
        .NUM_LINES (NL),
        .MEM_LAT   (ML)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Instruction memory: every word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return w * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    always_comb begin
        bus.mem_line = '0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_line[32*i +: 32] = mem_word(bus.mem_addr + 32'(4 * i));
        end
    end

    // Behavioural model: per-line valid/tag plus a count of remaining fill cycles.
    bit          m_known;
    bit          m_valid [NL];
    int unsigned m_tag   [NL];
    int          m_busy;
    logic [31:0] m_fill;
    logic [31:0] m_hc;
    logic [31:0] m_mc;
    logic        e_hit;
    logic        e_stall;
    logic [31:0] e_instr;
    logic [31:0] e_maddr;

    logic        cur_r;
    logic        cur_re;
    logic [31:0] cur_p;
    logic        cur_fl;

    int unsigned n_vec;
    int unsigned n_miss;

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / 32) % NL;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / (32 * NL);
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic clear_valids();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_eval();
        if (m_busy == 0) begin
            e_hit   = cur_re && !cur_fl && m_valid[idx_of(cur_p)] &&
                      (m_tag[idx_of(cur_p)] == tag_of(cur_p));
            e_stall = cur_re && !cur_fl && !e_hit;
            e_maddr = cur_p & ~32'h1F;
        end else begin
            e_hit   = 1'b0;
            e_stall = 1'b1;
            e_maddr = m_fill;
        end
        e_instr = e_hit ? mem_word(cur_p) : 32'h0;
    endtask

    task automatic model_update();
        if (cur_r) begin
            clear_valids();
            m_busy  = 0;
            m_hc    = 0;
            m_mc    = 0;
            m_known = 1'b1;
        end else if (m_busy == 0) begin
            if (cur_fl) begin
                clear_valids();
            end else if (e_hit) begin
                m_hc = sat(m_hc);
            end else if (cur_re) begin
                m_mc   = sat(m_mc);
                m_busy = ML + 1;
                m_fill = cur_p & ~32'h1F;
            end
        end else if (cur_fl) begin
            clear_valids();
            m_busy = 0;
        end else begin
            if (m_busy == 1) begin
                m_valid[idx_of(m_fill)] = 1'b1;
                m_tag[idx_of(m_fill)]   = tag_of(m_fill);
            end
            m_busy--;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic re, input logic [31:0] p, input logic fl);
        cur_r     = r;
        cur_re    = re;
        cur_p     = p;
        cur_fl    = fl;
        RST       = r;
        bus.rd_en = re;
        bus.pc    = p;
        bus.flush = fl;
        #1;
    endtask

    task automatic finish_cycle();
        model_eval();
        if (m_known) begin
            chk("hit",        32'(bus.hit),   32'(e_hit));
            chk("stall",      32'(bus.stall), 32'(e_stall));
            chk("instr",      bus.instr,      e_instr);
            chk("mem_addr",   bus.mem_addr,   e_maddr);
            chk("hit_count",  bus.hit_count,  m_hc);
            chk("miss_count", bus.miss_count, m_mc);
        end
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic step(input logic r, input logic re, input logic [31:0] p, input logic fl);
        drive(r, re, p, fl);
        finish_cycle();
    endtask

    // Fetch one pc until it hits; count the stall cycles seen on the way.
    task automatic fetch(input logic [31:0] p, input int exp_stalls, input string name);
        int   stalls;
        logic done;
        stalls = 0;
        done   = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            drive(1'b0, 1'b1, p, 1'b0);
            if (bus.hit) begin
                chk({name, "_instr"}, bus.instr, mem_word(p));
                done = 1'b1;
            end else if (bus.stall) begin
                stalls++;
            end
            finish_cycle();
        end
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    endtask

    typedef struct {
        logic        rd_en;
        logic [31:0] pc;
        logic        exp_hit;
        logic        exp_stall;
        logic [31:0] exp_maddr;
        logic [31:0] exp_hc;
        logic [31:0] exp_mc;
    } vec_t;

    vec_t tbl [13];

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        m_known = 1'b0;
        m_busy  = 0;
        m_fill  = '0;
        m_hc    = '0;
        m_mc    = '0;
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
        end

        // Cold miss on pc 0 (four stall cycles), then hits across the line.
        tbl[0]  = '{1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'd0, 32'd0};
        tbl[1]  = '{1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'd0, 32'd1};
        tbl[2]  = '{1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'd0, 32'd1};
        tbl[3]  = '{1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'd0, 32'd1};
        tbl[4]  = '{1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'd0, 32'd1};
        for (int i = 5; i < 12; i++) begin
            tbl[i] = '{1'b1, 32'(4 * (i - 4)), 1'b1, 1'b0, 32'h0, 32'(i - 4), 32'd1};
        end
        tbl[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'd8, 32'd1};

        RST       = 1'b1;
        bus.rd_en = 1'b0;
        bus.pc    = '0;
        bus.flush = 1'b0;
        @(negedge CLK);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);

        // Reset state, then the table.
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_hit",   32'(bus.hit),   32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_instr", bus.instr,      32'd0);
        finish_cycle();
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, tbl[i].rd_en, tbl[i].pc, 1'b0);
            chk($sformatf("tbl%0d_hit", i),   32'(bus.hit),   32'(tbl[i].exp_hit));
            chk($sformatf("tbl%0d_stall", i), 32'(bus.stall), 32'(tbl[i].exp_stall));
            chk($sformatf("tbl%0d_instr", i), bus.instr,
                tbl[i].exp_hit ? mem_word(tbl[i].pc) : 32'h0);
            chk($sformatf("tbl%0d_maddr", i), bus.mem_addr,   tbl[i].exp_maddr);
            chk($sformatf("tbl%0d_hc", i),    bus.hit_count,  tbl[i].exp_hc);
            chk($sformatf("tbl%0d_mc", i),    bus.miss_count, tbl[i].exp_mc);
            finish_cycle();
        end

        // Conflict: 0x0 and 0x200 share index 0.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        fetch(32'h0,   4, "conf_a");
        fetch(32'h200, 4, "conf_b");
        fetch(32'h0,   4, "conf_c");
        chk("conf_mc", bus.miss_count, 32'd3);

        // Flush in LOOKUP: no hit, no stall, line refetched afterwards.
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        chk("flush_hit",   32'(bus.hit),   32'd0);
        chk("flush_stall", 32'(bus.stall), 32'd0);
        finish_cycle();
        fetch(32'h0, 4, "post_flush");
        chk("flush_mc", bus.miss_count, 32'd4);

        // Flush during FILL_WAIT aborts the fill; the same pc misses again.
        step(1'b0, 1'b1, 32'h40, 1'b0);
        step(1'b0, 1'b1, 32'h40, 1'b1);
        drive(1'b0, 1'b1, 32'h40, 1'b0);
        chk("abort_hit",   32'(bus.hit),   32'd0);
        chk("abort_stall", 32'(bus.stall), 32'd1);
        finish_cycle();
        fetch(32'h40, 3, "abort_refill");
        chk("abort_mc", bus.miss_count, 32'd6);

        // Reset during FILL_WAIT, then idle cycles leave counters untouched.
        step(1'b0, 1'b1, 32'h80, 1'b0);
        step(1'b1, 1'b0, 32'h80, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h80, 1'b0);
            chk("idle_hit",   32'(bus.hit),   32'd0);
            chk("idle_stall", 32'(bus.stall), 32'd0);
            chk("idle_hc",    bus.hit_count,  32'd0);
            chk("idle_mc",    bus.miss_count, 32'd0);
            finish_cycle();
        end
        fetch(32'h80, 4, "post_rst");

        // Randomized traffic over a small address space to provoke conflicts.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] p;
            p = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, p,
                 $urandom_range(0, 99) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
